wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 The block SHALL expose port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 The block SHALL expose port in_valid, input, 1, EXU result valid.
REQ-004 The block SHALL expose port in_ready, output, 1, WBU can accept an EXU result.
REQ-005 The block SHALL expose port in_next_pc, input, 32, next PC of the instruction.
REQ-006 The block SHALL expose port in_rd, input, 5, destination register index.
REQ-007 The block SHALL expose port in_rd_wen, input, 1, instruction writes rd.
REQ-008 The block SHALL expose port in_alu_res, input, 32, ALU/CSR result for non-loads.
REQ-009 The block SHALL expose port in_is_load, input, 1, instruction is a load.
REQ-010 The block SHALL expose port in_funct3, input, 3, load width/sign code.
REQ-011 The block SHALL expose port in_addr_lo, input, 2, load address bits [1:0].
REQ-012 The block SHALL expose port mem_rvalid, input, 1, load data valid (arbitrary delay).
REQ-013 The block SHALL expose port mem_rready, output, 1, WBU accepts load data.
REQ-014 The block SHALL expose port mem_rdata, input, 32, aligned memory word.
REQ-015 The block SHALL expose port rf_wen, output, 1, register-file write enable.
REQ-016 The block SHALL expose port rf_waddr, output, 5, register-file write index.
REQ-017 The block SHALL expose port rf_wdata, output, 32, register-file write data.
REQ-018 The block SHALL expose port out_valid, output, 1, commit valid to IFU.
REQ-019 The block SHALL expose port out_ready, input, 1, IFU accepts commit.
REQ-020 The block SHALL expose port out_next_pc, output, 32, committed next PC.

Function
REQ-021 FSM states IDLE, WAIT_MEM, COMMIT SHALL be used; in_ready=1 only in IDLE, mem_rready=1 only in WAIT_MEM, out_valid=1 only in COMMIT.
REQ-022 IDLE with in_valid SHALL capture rd, rd_wen, next_pc, alu_res, funct3, addr_lo; next state WAIT_MEM if in_is_load else COMMIT.
REQ-023 WAIT_MEM SHALL hold until mem_rvalid; on mem_rvalid the extended load value SHALL replace the captured result and the state SHALL go to COMMIT; mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-024 Load extension: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane = addr_lo, halfword lane = addr_lo[1] (addr_lo[0] ignored); any other funct3 SHALL be treated as LW.
REQ-025 rf_wen SHALL be 1 exactly in the cycle out_valid and out_ready are both 1, and only if captured rd_wen=1 and rd!=0; rf_waddr/rf_wdata SHALL show captured rd/result throughout COMMIT.
REQ-026 COMMIT SHALL hold outputs stable until out_ready; on the handshake the state SHALL return to IDLE; exactly one register write per accepted instruction.
REQ-027 Minimum latency for a non-load SHALL be 1 cycle from in handshake to out_valid; for a load, 1 cycle after mem_rvalid.

Reset
REQ-028 rst_n low SHALL force IDLE immediately, out_valid=0, rf_wen=0, mem_rready=0, in_ready=1 after release, captured registers=0; a load or commit in flight SHALL be dropped with no RF write.

Configuration
REQ-029 With WBU_DIFFTEST_EN defined, outputs commit_valid (1, equals rf-write-handshake cycle out_valid&out_ready) and commit_wdata (32) SHALL be added for the simulation checker; without it these ports SHALL not exist and behaviour is otherwise identical.

Structure
REQ-030 The state enum and the funct3 load codes SHALL live in the shared CPU package npc_pkg.
REQ-031 Load extension SHALL be a combinational sub-module load_ext (inputs rdata, funct3, addr_lo; output 32-bit value).

Verification
REQ-032 ADD to rd=5 result 0x0000_1234, out_ready=1 -> out_valid next cycle, rf_wen=1, waddr=5, wdata=0x0000_1234 for one cycle.
REQ-033 LB addr_lo=2, mem_rdata=0x0080_0000 after 3-cycle delay -> wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 LH addr_lo=3, mem_rdata=0x8001_0000 -> wdata=0xFFFF_8001; LHU -> 0x0000_8001.
REQ-035 rd=0 with rd_wen=1 -> out_valid handshake occurs, rf_wen stays 0.
REQ-036 out_ready held low 4 cycles in COMMIT -> outputs stable, no rf_wen until out_ready=1, then single write.
REQ-037 rst_n asserted in WAIT_MEM, then mem_rvalid -> no rf_wen, state IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared CPU definitions: writeback FSM states and RV32 load funct3 codes.
package npc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load lane selection and sign/zero extension of an aligned 32-bit memory word.
module load_ext
    import npc_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // addr_lo[0] is don't-care for halfwords
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value = rdata;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LW:   value = rdata;
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: captures EXU results, waits for load data, commits to RF and IFU.
// Build option WBU_DIFFTEST_EN adds commit_valid/commit_wdata for the simulation checker.
//
// state    | meaning
// IDLE     | accepting an EXU result (in_ready=1)
// WAIT_MEM | load issued, waiting for mem_rvalid (mem_rready=1)
// COMMIT   | result held for IFU handshake (out_valid=1), RF write on handshake
module wbu
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_next_pc,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [31:0] in_alu_res,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_next_pc
`ifdef WBU_DIFFTEST_EN
    ,
    output logic        commit_valid,
    output logic [31:0] commit_wdata
`endif
);

    wbu_state_e  state, state_nxt;
    logic [4:0]  rd_q;
    logic        rd_wen_q;
    logic [31:0] next_pc_q;
    logic [31:0] res_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] load_val;

    load_ext u_load_ext (
        .rdata   (mem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .value   (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mem_rready = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_is_load ? WAIT_MEM : COMMIT;
            end
            WAIT_MEM: begin
                mem_rready = 1'b1;
                if (mem_rvalid) state_nxt = COMMIT;
            end
            COMMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= 5'd0;
            rd_wen_q  <= 1'b0;
            next_pc_q <= 32'd0;
            res_q     <= 32'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else begin
            if (state == IDLE && in_valid) begin
                rd_q      <= in_rd;
                rd_wen_q  <= in_rd_wen;
                next_pc_q <= in_next_pc;
                res_q     <= in_alu_res;
                funct3_q  <= in_funct3;
                addr_lo_q <= in_addr_lo;
            end
            if (state == WAIT_MEM && mem_rvalid) begin
                res_q <= load_val;
            end
        end
    end

    // x0 is hardwired; suppress its write here rather than relying on the RF
    assign rf_wen      = out_valid && out_ready && rd_wen_q && (rd_q != 5'd0);
    assign rf_waddr    = rd_q;
    assign rf_wdata    = res_q;
    assign out_next_pc = next_pc_q;

`ifdef WBU_DIFFTEST_EN
    assign commit_valid = out_valid && out_ready;
    assign commit_wdata = res_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed transactions against a behavioural commit model.
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] in_next_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_alu_res;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_valid, out_ready;
    logic [31:0] out_next_pc;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int exp_writes = 0;

    logic        exp_valid = 1'b0;
    logic        exp_wen = 1'b0;
    logic [4:0]  exp_rd = 5'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [31:0] exp_pc = 32'd0;

    always #5 clk = ~clk;

    wbu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_next_pc  (in_next_pc),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .in_alu_res  (in_alu_res),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_rdata   (mem_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_next_pc (out_next_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural load result: pick the lane by byte offset, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] lo);
        int unsigned b, h;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Per-cycle compare against the currently outstanding expected commit
    always begin
        @(negedge clk);
        #1;
        chk("one_state_active", 32'(in_ready) + 32'(mem_rready) + 32'(out_valid), 32'd1);
        chk("rf_wen_rule", 32'(rf_wen),
            32'(out_valid && out_ready && exp_valid && exp_wen && exp_rd != 5'd0));
        if (rf_wen) n_writes++;
        if (!exp_valid) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid) begin
            chk("commit_waddr", 32'(rf_waddr), 32'(exp_rd));
            chk("commit_wdata", rf_wdata, exp_wdata);
            chk("commit_pc", out_next_pc, exp_pc);
        end
    end

    task automatic txn(input string nm, input bit ld, input logic [4:0] rd, input bit wen,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] f3,
                       input logic [1:0] lo, input int mdly, input logic [31:0] mdata,
                       input int rdly);
        exp_rd    = rd;
        exp_wen   = wen;
        exp_pc    = pc;
        exp_wdata = ld ? model_load(mdata, f3, lo) : alu;
        if (wen && rd != 5'd0) exp_writes++;
        @(negedge clk);
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        exp_valid  = 1'b1;
        in_valid   = 1'b1;
        in_is_load = ld;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_next_pc = pc;
        in_alu_res = alu;
        in_funct3  = f3;
        in_addr_lo = lo;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_rd      = 5'($urandom);
        in_rd_wen  = 1'($urandom);
        in_next_pc = $urandom;
        in_alu_res = $urandom;
        in_funct3  = 3'($urandom);
        in_addr_lo = 2'($urandom);
        in_is_load = 1'($urandom);
        if (ld) begin
            @(negedge clk);
            chk({nm, ".mem_rready"}, 32'(mem_rready), 32'd1);
            repeat (mdly) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = mdata;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        chk({nm, ".latency_out_valid"}, 32'(out_valid), 32'd1);
        repeat (rdly) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        chk({nm, ".write_count"}, 32'(n_writes), 32'(exp_writes));
        chk({nm, ".back_to_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; in_next_pc = '0; in_rd = '0; in_rd_wen = 1'b0; in_alu_res = '0;
        in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;

        // Pin the model against hand-computed load results
        chk("model_lb",  model_load(32'h0080_0000, 3'b000, 2'd2), 32'hFFFF_FF80);
        chk("model_lbu", model_load(32'h0080_0000, 3'b100, 2'd2), 32'h0000_0080);
        chk("model_lh",  model_load(32'h8001_0000, 3'b001, 2'd3), 32'hFFFF_8001);
        chk("model_lhu", model_load(32'h8001_0000, 3'b101, 2'd3), 32'h0000_8001);
        chk("model_lw_alias", model_load(32'hDEAD_BEEF, 3'b011, 2'd1), 32'hDEAD_BEEF);

        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.rf_wen", 32'(rf_wen), 32'd0);
        chk("rst.mem_rready", 32'(mem_rready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.waddr", 32'(rf_waddr), 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        chk("rst.pc", out_next_pc, 32'd0);

        //   name        ld rd  wen pc             alu            f3      lo  mdly mdata          rdly
        txn("add_rd5",   0, 5,  1,  32'h8000_0004, 32'h0000_1234, 3'b000, 0,  0,   32'h0,         0);
        txn("lb_lane2",  1, 6,  1,  32'h8000_0008, 32'h1111_1111, 3'b000, 2,  3,   32'h0080_0000, 0);
        txn("lbu_lane2", 1, 7,  1,  32'h8000_000C, 32'h2222_2222, 3'b100, 2,  3,   32'h0080_0000, 0);
        txn("lh_lo3",    1, 8,  1,  32'h8000_0010, 32'h3333_3333, 3'b001, 3,  1,   32'h8001_0000, 0);
        txn("lhu_lo3",   1, 9,  1,  32'h8000_0014, 32'h4444_4444, 3'b101, 3,  0,   32'h8001_0000, 0);
        txn("lb_lane3",  1, 10, 1,  32'h8000_0018, 32'h0,         3'b000, 3,  2,   32'h7F12_3456, 0);
        txn("lh_lo0",    1, 11, 1,  32'h8000_001C, 32'h0,         3'b001, 0,  0,   32'h1234_F00D, 1);
        txn("lw",        1, 12, 1,  32'h8000_0020, 32'h0,         3'b010, 0,  2,   32'hCAFE_BABE, 0);
        txn("f3_011_lw", 1, 13, 1,  32'h8000_0024, 32'h0,         3'b011, 2,  0,   32'hA5A5_5A5A, 0);
        txn("rd0_wen",   0, 0,  1,  32'h8000_0028, 32'hFFFF_FFFF, 3'b000, 0,  0,   32'h0,         0);
        txn("wen0",      0, 7,  0,  32'h8000_002C, 32'h0BAD_F00D, 3'b000, 0,  0,   32'h0,         0);
        txn("stall4",    0, 31, 1,  32'h8000_0030, 32'h5555_AAAA, 3'b000, 0,  0,   32'h0,         4);
        txn("load_stall",1, 3,  1,  32'h8000_0034, 32'h0,         3'b100, 1,  2,   32'h0000_9900, 3);

        // mem_rvalid while idle must be ignored
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("idle_rvalid.in_ready", 32'(in_ready), 32'd1);
        chk("idle_rvalid.out_valid", 32'(out_valid), 32'd0);

        // Reset while a load is waiting for memory
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd9; in_rd_wen = 1'b1;
        in_next_pc = 32'h9000_0000; in_alu_res = 32'h7777_7777;
        in_funct3 = 3'b010; in_addr_lo = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstmem.mem_rready", 32'(mem_rready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmem.mem_rready_drop", 32'(mem_rready), 32'd0);
        chk("rstmem.out_valid", 32'(out_valid), 32'd0);
        chk("rstmem.rf_wen", 32'(rf_wen), 32'd0);
        chk("rstmem.wdata_clr", rf_wdata, 32'd0);
        chk("rstmem.waddr_clr", 32'(rf_waddr), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFEED_FACE;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rstmem.in_ready", 32'(in_ready), 32'd1);
        chk("rstmem.mem_rready_after", 32'(mem_rready), 32'd0);
        chk("rstmem.out_valid_after", 32'(out_valid), 32'd0);
        chk("rstmem.no_write", 32'(n_writes), 32'(exp_writes));

        txn("after_rst", 0, 4,  1,  32'h8000_0040, 32'h0000_0042, 3'b000, 0,  0,   32'h0,         1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
